// File: rtl/tea_if.sv
// tea_if: bundle of all block-level signals of the TEA engine.
//   Streaming input : s_valid, s_ready, s_data[2*HW-1:0], s_decrypt
//   Streaming output: m_valid, m_ready, m_data[2*HW-1:0]
//   APB config port : psel, penable, pwrite, paddr[7:0], pwdata[31:0],
//                     prdata[31:0], pready, pslverr
// Modport slave is the engine's view; master is the producer/consumer/APB side.
interface tea_if #(
    parameter int HW = 32
) ();
    logic            s_valid;
    logic            s_ready;
    logic [2*HW-1:0] s_data;
    logic            s_decrypt;
    logic            m_valid;
    logic            m_ready;
    logic [2*HW-1:0] m_data;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [7:0]      paddr;
    logic [31:0]     pwdata;
    logic [31:0]     prdata;
    logic            pready;
    logic            pslverr;

    modport slave (
        input  s_valid, s_data, s_decrypt, m_ready,
        input  psel, penable, pwrite, paddr, pwdata,
        output s_ready, m_valid, m_data,
        output prdata, pready, pslverr
    );

    modport master (
        output s_valid, s_data, s_decrypt, m_ready,
        output psel, penable, pwrite, paddr, pwdata,
        input  s_ready, m_valid, m_data,
        input  prdata, pready, pslverr
    );
endinterface

// File: rtl/tea_cipher.sv
// tea_cipher: iterative TEA block cipher, one round per clock, one block in
// flight. Half-block width HW (8..32) and round count 1<<SHIFT are
// parameters; encrypt/decrypt is chosen per block via s_decrypt.
// Ports:
//   clk    - clock for all logic
//   prstb  - asynchronous active-low reset
//   bus    - tea_if.slave: valid/ready input stream (s_*), valid/ready output
//            stream (m_*), and a zero-wait-state APB register port.
// Registers (byte addresses): 0x00..0x0C K0..K3, 0x10 DELTA (RW),
//   0x14 STATUS (RO: bit0 busy, bit1 m_valid, [15:8] rounds remaining),
//   0x18 BLOCKS (RO counter, any write clears). Other addresses -> pslverr.
module tea_cipher #(
    parameter int           HW    = 32,
    parameter int           SHIFT = 5,
    parameter logic [127:0] KEY   = 128'h0,
    parameter logic [31:0]  DELTA = 32'h9E3779B9
) (
    input logic clk,
    input logic prstb,
    tea_if.slave bus
);
    localparam logic [7:0] ROUNDS = 8'(1 << SHIFT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_reg, state_next;

    // Software-visible configuration; copied into the working set on accept
    // so that APB writes never disturb a block already in flight.
    logic [3:0][HW-1:0] cfg_key_reg;
    logic [HW-1:0]      cfg_delta_reg;

    // Working set for the block in flight.
    logic [3:0][HW-1:0] key_reg;
    logic [HW-1:0]      delta_reg;
    logic [HW-1:0]      v0_reg, v1_reg, sum_reg;
    logic               decrypt_reg;
    logic [7:0]         cnt_reg;

    logic [2*HW-1:0]    m_data_reg;
    logic [15:0]        blocks_reg;
    logic [31:0]        prdata_reg;
    logic               pslverr_reg;

    logic accept, last_round, handshake_out;
    logic apb_setup, apb_wr;
    logic [3:0] key_wr;
    logic delta_wr, blocks_clr;
    logic [31:0] rd_mux;
    logic rd_hit;

    logic [HW-1:0] enc_sum, enc_v0, enc_v1;
    logic [HW-1:0] dec_sum, dec_v0, dec_v1;
    logic [HW-1:0] rnd_v0, rnd_v1, rnd_sum;

    // TEA mixing term; all arithmetic wraps at HW bits.
    function automatic logic [HW-1:0] mix(
        input logic [HW-1:0] x,
        input logic [HW-1:0] s,
        input logic [HW-1:0] ka,
        input logic [HW-1:0] kb
    );
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    assign accept        = (state_reg == IDLE) && bus.s_valid;
    assign last_round    = (state_reg == RUN) && (cnt_reg == 8'd1);
    assign handshake_out = (state_reg == DONE) && bus.m_ready;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge prstb) begin
        if (!prstb) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.s_valid)     state_next = RUN;
            RUN:     if (cnt_reg == 8'd1) state_next = DONE;
            DONE:    if (bus.m_ready)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.s_ready = (state_reg == IDLE);
    assign bus.m_valid = (state_reg == DONE);
    assign bus.m_data  = m_data_reg;

    // ------------------------------------------------------------------
    // Round datapath. Encrypt pre-increments sum; decrypt uses the current
    // sum and post-decrements, so decrypt starts from delta*ROUNDS.
    // ------------------------------------------------------------------
    always_comb begin
        enc_sum = sum_reg + delta_reg;
        enc_v0  = v0_reg + mix(v1_reg, enc_sum, key_reg[0], key_reg[1]);
        enc_v1  = v1_reg + mix(enc_v0, enc_sum, key_reg[2], key_reg[3]);

        dec_v1  = v1_reg - mix(v0_reg, sum_reg, key_reg[2], key_reg[3]);
        dec_v0  = v0_reg - mix(dec_v1, sum_reg, key_reg[0], key_reg[1]);
        dec_sum = sum_reg - delta_reg;

        rnd_v0  = decrypt_reg ? dec_v0  : enc_v0;
        rnd_v1  = decrypt_reg ? dec_v1  : enc_v1;
        rnd_sum = decrypt_reg ? dec_sum : enc_sum;
    end

    always_ff @(posedge clk or negedge prstb) begin
        if (!prstb) begin
            key_reg     <= '0;
            delta_reg   <= '0;
            v0_reg      <= '0;
            v1_reg      <= '0;
            sum_reg     <= '0;
            decrypt_reg <= 1'b0;
            cnt_reg     <= '0;
            m_data_reg  <= '0;
        end else begin
            if (accept) begin
                v0_reg      <= bus.s_data[HW-1:0];
                v1_reg      <= bus.s_data[2*HW-1:HW];
                decrypt_reg <= bus.s_decrypt;
                key_reg     <= cfg_key_reg;
                delta_reg   <= cfg_delta_reg;
                sum_reg     <= bus.s_decrypt ? (cfg_delta_reg << SHIFT) : '0;
                cnt_reg     <= ROUNDS;
            end else if (state_reg == RUN) begin
                v0_reg  <= rnd_v0;
                v1_reg  <= rnd_v1;
                sum_reg <= rnd_sum;
                cnt_reg <= cnt_reg - 8'd1;
                if (last_round) begin
                    m_data_reg <= {rnd_v1, rnd_v0};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // APB register port
    // ------------------------------------------------------------------
    assign apb_setup  = bus.psel && !bus.penable;
    assign apb_wr     = bus.psel && bus.penable && bus.pwrite;
    assign delta_wr   = apb_wr && (bus.paddr == 8'h10);
    assign blocks_clr = apb_wr && (bus.paddr == 8'h18);

    for (genvar gi = 0; gi < 4; gi++) begin : g_key_dec
        assign key_wr[gi] = apb_wr && (bus.paddr == 8'(gi * 4));
    end

    always_ff @(posedge clk or negedge prstb) begin
        if (!prstb) begin
            for (int i = 0; i < 4; i++) begin
                cfg_key_reg[i] <= KEY[32*i +: HW];
            end
            cfg_delta_reg <= DELTA[HW-1:0];
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_wr[i]) begin
                    cfg_key_reg[i] <= bus.pwdata[HW-1:0];
                end
            end
            if (delta_wr) begin
                cfg_delta_reg <= bus.pwdata[HW-1:0];
            end
        end
    end

    // A clear wins over a simultaneous increment.
    always_ff @(posedge clk or negedge prstb) begin
        if (!prstb) begin
            blocks_reg <= '0;
        end else if (blocks_clr) begin
            blocks_reg <= '0;
        end else if (handshake_out) begin
            blocks_reg <= blocks_reg + 16'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        rd_hit = 1'b1;
        case (bus.paddr)
            8'h00:   rd_mux = 32'(cfg_key_reg[0]);
            8'h04:   rd_mux = 32'(cfg_key_reg[1]);
            8'h08:   rd_mux = 32'(cfg_key_reg[2]);
            8'h0C:   rd_mux = 32'(cfg_key_reg[3]);
            8'h10:   rd_mux = 32'(cfg_delta_reg);
            8'h14:   rd_mux = {16'h0, cnt_reg, 6'h0, (state_reg == DONE), (state_reg == RUN)};
            8'h18:   rd_mux = {16'h0, blocks_reg};
            default: rd_hit = 1'b0;
        endcase
    end

    // Read data and error status are captured in the setup phase so they are
    // stable for the whole access phase.
    always_ff @(posedge clk or negedge prstb) begin
        if (!prstb) begin
            prdata_reg  <= '0;
            pslverr_reg <= 1'b0;
        end else if (apb_setup) begin
            prdata_reg  <= rd_mux;
            pslverr_reg <= !rd_hit;
        end
    end

    assign bus.prdata  = prdata_reg;
    assign bus.pslverr = pslverr_reg && bus.psel && bus.penable;
    assign bus.pready  = 1'b1;
endmodule

// File: tb/tb_tea_cipher.sv
// tb_tea_cipher: directed bench for tea_cipher. A HW=32/32-round instance
// covers the register map, handshakes, stalls and reset; a HW=16/8-round
// instance is checked against the legacy-size reference. A loop-based TEA
// reference produces the expected blocks; a single compare process checks
// m_data against it on every cycle m_valid is high.
module tb_tea_cipher;
    localparam logic [127:0] KEY16 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    logic clk = 1'b0;
    logic prstb = 1'b0;
    always #5 clk = ~clk;

    tea_if #(.HW(32)) b32 ();
    tea_if #(.HW(16)) b16 ();

    tea_cipher #(.HW(32), .SHIFT(5)) dut32 (
        .clk   (clk),
        .prstb (prstb),
        .bus   (b32)
    );

    tea_cipher #(.HW(16), .SHIFT(3), .KEY(KEY16)) dut16 (
        .clk   (clk),
        .prstb (prstb),
        .bus   (b16)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [127:0] key32   = 128'h0;
    logic [31:0]  delta32 = 32'h9E3779B9;
    logic [63:0]  exp_q32[$];
    logic [63:0]  exp_q16[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired, required event never seen", name);
    endtask

    // Classic TEA written as a plain loop over masked 64-bit arithmetic.
    function automatic logic [63:0] tea_ref(input int hw, input int rounds, input logic [63:0] blk,
                                            input logic [127:0] key, input logic [31:0] delta,
                                            input bit dec);
        logic [63:0] m, v0, v1, s, d;
        logic [63:0] k[4];
        m  = (64'd1 << hw) - 64'd1;
        v0 = blk & m;
        v1 = (blk >> hw) & m;
        d  = {32'd0, delta} & m;
        for (int i = 0; i < 4; i++) k[i] = {32'd0, key[32*i +: 32]} & m;
        if (!dec) begin
            s = 64'd0;
            for (int r = 0; r < rounds; r++) begin
                s  = (s + d) & m;
                v0 = (v0 + ((((v1 << 4) + k[0]) ^ (v1 + s) ^ ((v1 >> 5) + k[1])))) & m;
                v1 = (v1 + ((((v0 << 4) + k[2]) ^ (v0 + s) ^ ((v0 >> 5) + k[3])))) & m;
            end
        end else begin
            s = (d * 64'(rounds)) & m;
            for (int r = 0; r < rounds; r++) begin
                v1 = (v1 - ((((v0 << 4) + k[2]) ^ (v0 + s) ^ ((v0 >> 5) + k[3])))) & m;
                v0 = (v0 - ((((v1 << 4) + k[0]) ^ (v1 + s) ^ ((v1 >> 5) + k[1])))) & m;
                s  = (s - d) & m;
            end
        end
        return (v1 << hw) | v0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb32(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
        b32.psel = 1'b1; b32.penable = 1'b0; b32.pwrite = wr;
        b32.paddr = addr; b32.pwdata = wd;
        tick();
        b32.penable = 1'b1;
        #1;
        rd  = b32.prdata;
        err = b32.pslverr;
        tick();
        b32.psel = 1'b0; b32.penable = 1'b0; b32.pwrite = 1'b0;
        if (wr) begin
            case (addr)
                8'h00: key32[31:0]   = wd;
                8'h04: key32[63:32]  = wd;
                8'h08: key32[95:64]  = wd;
                8'h0C: key32[127:96] = wd;
                8'h10: delta32       = wd;
                default: ;
            endcase
        end
    endtask

    task automatic wr32(input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        logic err;
        apb32(1'b1, addr, wd, rd, err);
    endtask

    task automatic rd32(input logic [7:0] addr, output logic [31:0] rd, output logic err);
        apb32(1'b0, addr, 32'h0, rd, err);
    endtask

    task automatic send32(input logic [63:0] din, input bit dec);
        int guard;
        guard = 0;
        b32.s_valid = 1'b1; b32.s_data = din; b32.s_decrypt = dec;
        while (!b32.s_ready && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) timeout("accept32");
        exp_q32.push_back(tea_ref(32, 32, din, key32, delta32, dec));
        tick();
        b32.s_valid = 1'b0;
    endtask

    // Counts from the cycle s_valid was presented (accept cycle = 1).
    task automatic wait32(output int lat);
        lat = 1;
        while (!b32.m_valid && lat < 300) begin
            tick();
            lat++;
        end
        if (!b32.m_valid) timeout("m_valid32");
    endtask

    task automatic take32(output logic [63:0] dout);
        b32.m_ready = 1'b1;
        dout = b32.m_data;
        tick();
    endtask

    task automatic blk32(input logic [63:0] din, input bit dec, output logic [63:0] dout);
        int lat;
        send32(din, dec);
        wait32(lat);
        take32(dout);
    endtask

    task automatic blk16(input logic [63:0] din, input bit dec, output logic [63:0] dout);
        int guard;
        guard = 0;
        b16.s_valid = 1'b1; b16.s_data = din[31:0]; b16.s_decrypt = dec;
        while (!b16.s_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) timeout("accept16");
        exp_q16.push_back(tea_ref(16, 8, din, KEY16, 32'h9E3779B9, dec));
        tick();
        b16.s_valid = 1'b0;
        guard = 0;
        while (!b16.m_valid && guard < 100) begin
            tick();
            guard++;
        end
        if (!b16.m_valid) timeout("m_valid16");
        b16.m_ready = 1'b1;
        dout = {32'd0, b16.m_data};
        tick();
    endtask

    // Compare process: every cycle an output is valid it must equal the
    // oldest outstanding expectation; a handshake retires that entry.
    always @(negedge clk) begin
        if (prstb && b32.m_valid) begin
            if (exp_q32.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL out32_spurious: got m_valid=1 data %h, required no output", b32.m_data);
            end else begin
                chk("m_data32", b32.m_data, exp_q32[0]);
                if (b32.m_ready) void'(exp_q32.pop_front());
            end
        end
        if (prstb && b16.m_valid) begin
            if (exp_q16.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL out16_spurious: got m_valid=1 data %h, required no output", b16.m_data);
            end else begin
                chk("m_data16", {32'd0, b16.m_data}, exp_q16[0]);
                if (b16.m_ready) void'(exp_q16.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic err;
        logic [63:0] c, p, d, d0;
        logic [127:0] old_key;
        int lat;

        b32.s_valid = 0; b32.s_data = '0; b32.s_decrypt = 0; b32.m_ready = 1;
        b32.psel = 0; b32.penable = 0; b32.pwrite = 0; b32.paddr = '0; b32.pwdata = '0;
        b16.s_valid = 0; b16.s_data = '0; b16.s_decrypt = 0; b16.m_ready = 1;
        b16.psel = 0; b16.penable = 0; b16.pwrite = 0; b16.paddr = '0; b16.pwdata = '0;

        repeat (3) tick();
        chk("rst_s_ready", 64'(b32.s_ready), 64'd1);
        chk("rst_m_valid", 64'(b32.m_valid), 64'd0);
        chk("rst_m_data", b32.m_data, 64'd0);
        chk("rst_prdata", 64'(b32.prdata), 64'd0);
        chk("rst_pslverr", 64'(b32.pslverr), 64'd0);
        prstb = 1'b1;
        tick();

        // Pin the reference model to published values.
        chk("ref_enc0", tea_ref(32, 32, 64'd0, 128'd0, 32'h9E3779B9, 1'b0), 64'h94BAA940_41EA3A0A);
        chk("ref_dec0", tea_ref(32, 32, 64'h94BAA940_41EA3A0A, 128'd0, 32'h9E3779B9, 1'b1), 64'd0);

        rd32(8'h00, rd, err);
        chk("rst_k0", 64'(rd), 64'd0);
        chk("k0_pslverr", 64'(err), 64'd0);
        rd32(8'h10, rd, err);
        chk("rst_delta", 64'(rd), 64'h9E3779B9);
        rd32(8'h18, rd, err);
        chk("rst_blocks", 64'(rd), 64'd0);

        // Known-answer encrypt, latency, then decrypt back.
        send32(64'd0, 1'b0);
        wait32(lat);
        chk("latency", 64'(lat), 64'd33);
        take32(c);
        chk("kat_enc", c, 64'h94BAA940_41EA3A0A);
        blk32(c, 1'b1, p);
        chk("kat_dec", p, 64'd0);
        rd32(8'h18, rd, err);
        chk("blocks_2", 64'(rd), 64'd2);

        // Consumer stall for 50 cycles.
        b32.m_ready = 1'b0;
        send32(64'h01234567_89ABCDEF, 1'b0);
        wait32(lat);
        d0 = b32.m_data;
        repeat (50) tick();
        chk("stall_m_data", b32.m_data, d0);
        chk("stall_s_ready", 64'(b32.s_ready), 64'd0);
        chk("stall_m_valid", 64'(b32.m_valid), 64'd1);
        rd32(8'h18, rd, err);
        chk("stall_blocks", 64'(rd), 64'd2);
        rd32(8'h14, rd, err);
        chk("stall_status", 64'(rd), 64'h2);
        b32.m_ready = 1'b1;
        tick();
        chk("release_s_ready", 64'(b32.s_ready), 64'd1);
        rd32(8'h18, rd, err);
        chk("release_blocks", 64'(rd), 64'd3);

        // Key write while a block is running.
        wr32(8'h00, 32'hA5A5A5A5);
        wr32(8'h04, 32'h01020304);
        wr32(8'h08, 32'hDEADBEEF);
        wr32(8'h0C, 32'h0BADF00D);
        old_key = key32;
        d = 64'hFEDCBA98_76543210;
        send32(d, 1'b0);
        rd32(8'h14, rd, err);
        chk("run_status", 64'(rd), 64'h2001);
        wr32(8'h00, 32'h12345678);
        wait32(lat);
        take32(c);
        chk("oldkey_result", c, tea_ref(32, 32, d, old_key, 32'h9E3779B9, 1'b0));
        rd32(8'h00, rd, err);
        chk("k0_readback", 64'(rd), 64'h12345678);
        blk32(d, 1'b0, c);
        chk("newkey_result", c, tea_ref(32, 32, d, {old_key[127:32], 32'h12345678}, 32'h9E3779B9, 1'b0));

        // Unmapped address and BLOCKS clear.
        rd32(8'h20, rd, err);
        chk("bad_addr_pslverr", 64'(err), 64'd1);
        chk("bad_addr_prdata", 64'(rd), 64'd0);
        wr32(8'h20, 32'hFFFFFFFF);
        rd32(8'h00, rd, err);
        chk("bad_wr_no_effect", 64'(rd), 64'h12345678);
        rd32(8'h18, rd, err);
        chk("blocks_5", 64'(rd), 64'd5);
        wr32(8'h18, 32'h0);
        rd32(8'h18, rd, err);
        chk("blocks_clear", 64'(rd), 64'd0);

        // Clear on the same edge as an output handshake leaves 0.
        b32.m_ready = 1'b0;
        send32(64'h00000001_00000002, 1'b0);
        wait32(lat);
        b32.psel = 1; b32.penable = 0; b32.pwrite = 1; b32.paddr = 8'h18; b32.pwdata = 32'h0;
        tick();
        b32.penable = 1;
        b32.m_ready = 1;
        tick();
        b32.psel = 0; b32.penable = 0; b32.pwrite = 0;
        rd32(8'h18, rd, err);
        chk("clear_vs_incr", 64'(rd), 64'd0);

        // Round trips on both instances in parallel.
        fork
            begin : rt32
                logic [63:0] pt, ct, bk;
                for (int i = 0; i < 500; i++) begin
                    wr32(8'h00, $urandom);
                    wr32(8'h04, $urandom);
                    wr32(8'h08, $urandom);
                    wr32(8'h0C, $urandom);
                    wr32(8'h10, $urandom);
                    pt = {$urandom, $urandom};
                    blk32(pt, 1'b0, ct);
                    blk32(ct, 1'b1, bk);
                    chk("roundtrip32", bk, pt);
                end
            end
            begin : rt16
                logic [63:0] pt, ct, bk;
                for (int i = 0; i < 500; i++) begin
                    pt = {32'd0, $urandom};
                    blk16(pt, 1'b0, ct);
                    blk16(ct, 1'b1, bk);
                    chk("roundtrip16", bk, pt);
                end
            end
        join

        // Reset in the middle of a block.
        send32(64'h11112222_33334444, 1'b0);
        repeat (9) tick();
        exp_q32.delete();
        prstb = 1'b0;
        #1;
        chk("midrst_m_valid", 64'(b32.m_valid), 64'd0);
        chk("midrst_s_ready", 64'(b32.s_ready), 64'd1);
        chk("midrst_m_data", b32.m_data, 64'd0);
        tick();
        tick();
        prstb = 1'b1;
        key32 = 128'h0;
        delta32 = 32'h9E3779B9;
        repeat (40) tick();
        chk("post_rst_no_output", 64'(b32.m_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            rd32(8'(4 * i), rd, err);
            chk("post_rst_key", 64'(rd), 64'd0);
        end
        rd32(8'h10, rd, err);
        chk("post_rst_delta", 64'(rd), 64'h9E3779B9);
        rd32(8'h18, rd, err);
        chk("post_rst_blocks", 64'(rd), 64'd0);
        blk32(64'd0, 1'b0, c);
        chk("post_rst_kat", c, 64'h94BAA940_41EA3A0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/tea_cipher.md
# tea_cipher

Parametrised TEA block cipher engine, the successor to the fixed 16-bit/8-round encryptor. It has configurable half-word width and round count, runtime encrypt/decrypt mode, valid/ready streaming handshakes on input and output, and an APB-style configuration port on the same clock. Key and delta are snapshotted per block, and a completed-block counter is provided. It sits between a data producer and a consumer as a one-block-in-flight, one-round-per-cycle iterative core.

## Interface
- HW, 32: half-block width in bits, 8..32; block is 2*HW bits.
- SHIFT, 5: round count ROUNDS = 1<<SHIFT, 1..6.
- KEY, 128'h0: reset key, {K3,K2,K1,K0}, each 32 bits; low HW bits used.
- DELTA, 32'h9E3779B9: reset delta; low HW bits used.
- clk  in  1  clock for all logic.
- prstb  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input block valid.
- s_ready  out  1  engine idle, can accept.
- s_data  in  2*HW  input block; [HW-1:0]=v0, [2HW-1:HW]=v1.
- s_decrypt  in  1  mode for this block: 0 encrypt, 1 decrypt.
- m_valid  out  1  output block valid.
- m_ready  in  1  consumer accepts.
- m_data  out  2*HW  result block, same packing.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  8  byte address.
- pwdata  in  32  write data.
- prdata  out  32  read data, valid in access phase.
- pready  out  1  tied 1.
- pslverr  out  1  error on unmapped address.

## Operation
- FSM: IDLE -> RUN -> DONE -> IDLE. s_ready = (state==IDLE). m_valid = (state==DONE).
- IDLE: on s_valid&&s_ready, latch v0/v1, mode, K0..K3 and delta (snapshot); round counter = ROUNDS; sum = 0 (encrypt) or delta<<SHIFT mod 2^HW (decrypt); go RUN.
- RUN, one round per cycle, all arithmetic mod 2^HW, shifts logical within HW bits:
  - encrypt: sum+=delta; v0+=((v1<<4)+K0)^(v1+sum)^((v1>>5)+K1); v1+=((v0'<<4)+K2)^(v0'+sum)^((v0'>>5)+K3), where v0' is the updated v0.
  - decrypt: v1-=((v0<<4)+K2)^(v0+sum)^((v0>>5)+K3); v0-=((v1'<<4)+K0)^(v1'+sum)^((v1'>>5)+K1), where v1' is the updated v1; then sum-=delta.
  - Counter decrements; on the round where it reaches 0, register m_data and go DONE.
- DONE: hold m_data stable; on m_ready, go IDLE and increment BLOCKS (16-bit, wraps).
- Register map (32-bit; HW-wide fields, upper bits read 0, write ignored):
  - 0x00 K0, 0x04 K1, 0x08 K2, 0x0C K3, 0x10 DELTA: RW.
  - 0x14 STATUS: RO; bit0 busy (RUN), bit1 m_valid, [15:8] rounds remaining.
  - 0x18 BLOCKS: RO count; any write clears it. A clear coinciding with an increment leaves 0.
- Writes commit when psel&&penable&&pwrite. Writes during RUN/DONE affect only the next accepted block.
- Any other paddr: prdata=0, pslverr=1 in the access phase; no state change.

## Timing
- Reset (prstb low, async): state IDLE, s_ready=1, m_valid=0, m_data=0, prdata=0, pslverr=0, BLOCKS=0, K*=KEY slices, DELTA=DELTA. Reset mid-block discards the block; no output is produced.
- Accept at edge T. Rounds occur at edges T+1..T+ROUNDS. m_valid is high after edge T+ROUNDS. Latency is ROUNDS+1 cycles from s_valid to m_valid with m_ready held high.
- The earliest next accept is the edge after the m_ready handshake (s_ready high one cycle later). Throughput is one block per ROUNDS+2 cycles.
- m_valid stays high and m_data is unchanged until m_ready; the consumer may stall indefinitely.
- APB has zero wait states. prdata is registered in the setup phase and valid when penable is high.

## Test plan
- HW=32, SHIFT=5, key 0, encrypt s_data=64'h0 -> m_data={v1=32'h94BAA940, v0=32'h41EA3A0A}, m_valid exactly 33 cycles after accept.
- Decrypt the above ciphertext with key 0 -> m_data=0. Repeat with random keys/blocks for 1000 encrypt->decrypt round trips, all matching the plaintext.
- Hold m_ready=0 for 50 cycles after completion -> m_data stable, s_ready=0, BLOCKS unchanged; release -> BLOCKS increments by 1, s_ready=1 next cycle.
- Write K0=32'h12345678 during RUN -> current result equals the old-key reference; next block uses the new key. Read back 0x00 = 32'h12345678.
- Assert prstb low at round 10 -> m_valid=0, s_ready=1, key registers = KEY; no spurious output after release.
- APB read of 0x20 -> pslverr=1, prdata=0. Write 0x18 -> BLOCKS reads 0. HW=16, SHIFT=3 run matches the 16-bit/8-round legacy model.
